// File: rtl/cs_pkg.sv
// cs_pkg: shared types and constants for the windowed averaging
// sequencer and its datapath.
package cs_pkg;

  localparam int CS_WIN = 9;
  localparam int CS_XW  = 8;
  localparam int CS_YW  = 10;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    FLUSH
  } state_t;

endpackage

// File: rtl/cs_seq_if.sv
// cs_seq_if: sample input stream and result output stream
// of the averaging sequencer.
interface cs_seq_if;
  import cs_pkg::*;

  logic             in_valid;
  logic [CS_XW-1:0] in_data;
  logic             in_ready;
  logic [CS_YW-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  y,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output y,
    output out_valid,
    output out_last
  );

endinterface

// File: rtl/cs_seq_cnt.sv
// cs_seq_cnt: up-counter with clear and enable that holds at TERM.
// hit flags the enabled increment that reaches TERM.
module cs_seq_cnt #(
  parameter int W    = 4,
  parameter int TERM = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term,
  output logic hit
);

  localparam logic [W-1:0] T_VAL  = W'(TERM);
  localparam logic [W-1:0] T_PREV = W'(TERM - 1);

  logic [W-1:0] q;

  assign term = (q == T_VAL);
  assign hit  = en & (q == T_PREV);

  // Count enabled events, saturating at the terminal value
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en && !term) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cs_seq.sv
// cs_seq: sequencer for the 9-sample windowed averaging datapath.
// Paces the sample stream, captures results, flushes between frames.
module cs_seq
  import cs_pkg::*;
#(
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  cs_seq_if.slave          io,
  output logic [CS_XW-1:0] cs_x,
  output logic             cs_shift,
  output logic             cs_clear,
  input  logic [CS_YW-1:0] cs_y,
  output logic             busy,
  output logic             done
);

  localparam int FILL_W = $clog2(CS_WIN + 1);

  state_t           state;
  logic             cap_pend;
  logic             pend_last;
  logic [CS_YW-1:0] y_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic active;
  logic can_cap;
  logic abort_hit;
  logic in_ready;
  logic accept;
  logic cap_trig;
  logic flush;
  logic fill_term;
  logic fill_hit;
  logic frame_term;
  logic frame_hit;

  assign active    = (state == FILL) | (state == RUN);
  assign can_cap   = ~out_valid_q | io.out_ready;
  assign abort_hit = abort & (state != IDLE);
  assign flush     = (state == FLUSH);

  // A pending capture may only be overtaken once it can land in y,
  // so cs_y is never shifted away before it is registered.
  assign in_ready = active & ~frame_term & ~abort
                  & (~cap_pend | can_cap);
  assign accept   = io.in_valid & in_ready;
  assign cap_trig = accept & (fill_hit | fill_term);

  assign cs_x         = io.in_data;
  assign cs_shift     = accept;
  assign io.in_ready  = in_ready;
  assign io.y         = y_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;

  cs_seq_cnt #(
    .W    (FILL_W),
    .TERM (CS_WIN)
  ) u_fill (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (accept),
    .term  (fill_term),
    .hit   (fill_hit)
  );

  cs_seq_cnt #(
    .W    (16),
    .TERM (FRAME_LEN)
  ) u_frame (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (accept),
    .term  (frame_term),
    .hit   (frame_hit)
  );

  // Frame FSM plus result capture and output handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs_clear    <= 1'b0;
      cap_pend    <= 1'b0;
      pend_last   <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      done     <= 1'b0;
      cs_clear <= 1'b0;
      cap_pend <= cap_trig | (cap_pend & ~can_cap);
      if (cap_trig) begin
        pend_last <= frame_hit;
      end
      if (cap_pend && can_cap) begin
        y_q         <= cs_y;
        out_valid_q <= 1'b1;
        out_last_q  <= pend_last;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (abort_hit) begin
        state       <= FLUSH;
        busy        <= 1'b1;
        done        <= 1'b1;
        cs_clear    <= 1'b1;
        cap_pend    <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= FILL;
              busy  <= 1'b1;
            end
          end
          FILL: begin
            if (frame_hit) begin
              state <= DRAIN;
            end else if (fill_hit) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (frame_hit) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!cap_pend && !out_valid_q) begin
              state    <= FLUSH;
              done     <= 1'b1;
              cs_clear <= 1'b1;
            end
          end
          FLUSH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cs_seq.sv
// tb_cs_seq: randomized self-checking bench for cs_seq, with a
// behavioural stand-in for the averaging datapath (y = sum/4).
module tb_cs_seq;
  import cs_pkg::*;

  localparam int FL = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CS_XW-1:0] cs_x;
  logic             cs_shift;
  logic             cs_clear;
  logic [CS_YW-1:0] cs_y;
  logic             busy;
  logic             done;

  cs_seq_if io();

  cs_seq #(.FRAME_LEN(FL)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .io       (io),
    .cs_x     (cs_x),
    .cs_shift (cs_shift),
    .cs_clear (cs_clear),
    .cs_y     (cs_y),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath stand-in: 9-deep window, result is window sum / 4
  logic [CS_XW-1:0] win [CS_WIN];
  logic [11:0]      wsum;

  always_ff @(posedge clk) begin
    if (reset || cs_clear) begin
      for (int i = 0; i < CS_WIN; i++) win[i] <= '0;
    end else if (cs_shift) begin
      for (int i = CS_WIN - 1; i > 0; i--) win[i] <= win[i-1];
      win[0] <= cs_x;
    end
  end

  always_comb begin
    wsum = '0;
    for (int i = 0; i < CS_WIN; i++) wsum = wsum + 12'(win[i]);
    cs_y = 10'(wsum >> 2);
  end

  int checks;
  int failures;
  int cyc;

  byte unsigned acc[$];
  int           exp_y[$];
  bit           exp_l[$];

  int nacc, nres, nshift, nclr, ndone;
  int cyc9, first_ov, first_y, last_pop, done_cyc;
  int stall_acc, max_stall, hold_bad, xbad;
  bit hold;
  logic [CS_YW-1:0] hold_y;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // observe one cycle: handshakes, reference results, pulse counts
  task automatic sample();
    int s;
    int ey;
    bit el;
    @(negedge clk);
    cyc++;
    if (reset) begin
      hold = 1'b0;
      stall_acc = 0;
      return;
    end
    if (io.in_valid && io.in_ready) begin
      acc.push_back(io.in_data);
      nacc++;
      if (nacc == CS_WIN) cyc9 = cyc;
      if (nacc >= CS_WIN) begin
        s = 0;
        for (int j = 0; j < CS_WIN; j++) s += acc[acc.size() - 1 - j];
        exp_y.push_back(s / 4);
        exp_l.push_back(nacc == FL);
      end
      if (io.out_valid && !io.out_ready) begin
        stall_acc++;
        if (stall_acc > max_stall) max_stall = stall_acc;
      end
    end
    if (!(io.out_valid && !io.out_ready)) stall_acc = 0;
    if (cs_shift) begin
      nshift++;
      if (cs_x !== io.in_data) xbad++;
    end
    if (io.out_valid && first_ov < 0) begin
      first_ov = cyc;
      first_y = int'(io.y);
    end
    if (hold && (!io.out_valid || io.y !== hold_y)) hold_bad++;
    hold = io.out_valid && !io.out_ready;
    hold_y = io.y;
    if (io.out_valid && io.out_ready) begin
      nres++;
      if (exp_y.size() == 0) begin
        check("spurious_y", 1, 0);
      end else begin
        ey = exp_y.pop_front();
        el = exp_l.pop_front();
        check("y", io.y, ey);
        check("last", io.out_last, el);
        if (el) last_pop = cyc;
      end
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (cs_clear) nclr++;
    if (abort && busy) begin
      exp_y.delete();
      exp_l.delete();
      hold = 1'b0;
    end
  endtask

  task automatic frame_begin();
    acc.delete();
    exp_y.delete();
    exp_l.delete();
    nacc = 0; nres = 0; nshift = 0; nclr = 0; ndone = 0;
    cyc9 = 0; first_ov = -1; first_y = -1;
    last_pop = 0; done_cyc = 0;
    stall_acc = 0; max_stall = 0; hold_bad = 0; xbad = 0;
  endtask

  task automatic start_frame();
    frame_begin();
    io.in_valid = 1'b0;
    start = 1'b1;
    sample();
    adv();
    start = 1'b0;
    sample();
    check("busy_start", busy, 1);
    adv();
  endtask

  // mode 0 random data, 1 constant 10, 2 ramp 1,2,3...
  task automatic run_frame(int vpct, int rpct, int mode, bit stall);
    int guard;
    bit stalled;
    start_frame();
    guard = 0;
    stalled = 1'b0;
    while (nacc < FL && guard < 3000) begin
      guard++;
      if (stall && !stalled && nacc == 11) begin
        stalled = 1'b1;
        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        repeat (5) begin
          io.in_data = 8'($urandom);
          sample();
          adv();
        end
      end else begin
        io.in_valid = ($urandom_range(99) < vpct);
        if (mode == 1) io.in_data = 8'd10;
        else if (mode == 2) io.in_data = 8'(nacc + 1);
        else io.in_data = 8'($urandom);
        io.out_ready = ($urandom_range(99) < rpct);
        sample();
        adv();
      end
    end
    io.in_valid = 1'b1;
    io.out_ready = ($urandom_range(99) < rpct);
    sample();
    check("drain_ready", io.in_ready, 0);
    adv();
    guard = 0;
    while (ndone == 0 && guard < 500) begin
      guard++;
      io.out_ready = ($urandom_range(99) < rpct);
      sample();
      adv();
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    sample();
    check("idle_busy", busy, 0);
    check("idle_ready", io.in_ready, 0);
    adv();
    check("done_seen", ndone, 1);
    check("accepts", nacc, FL);
    check("results", nres, FL - 8);
    check("pending", exp_y.size(), 0);
    check("shift_cnt", nshift, nacc);
    check("clear_cnt", nclr, 1);
    check("latency", first_ov - cyc9, 2);
    check("done_gap", done_cyc - last_pop, 2);
    check("stall_ok", (max_stall <= 1), 1);
    check("hold", hold_bad, 0);
    check("cs_x", xbad, 0);
    if (mode == 1) check("const_y", first_y, 22);
    if (mode == 2) check("ramp_y", first_y, 11);
  endtask

  task automatic abort_frame();
    int guard;
    start_frame();
    guard = 0;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    while (nacc < 11 && guard < 200) begin
      guard++;
      io.in_data = 8'($urandom);
      sample();
      adv();
    end
    abort = 1'b1;
    sample();
    check("abort_block", io.in_ready, 0);
    adv();
    abort = 1'b0;
    io.in_valid = 1'b0;
    sample();
    check("abort_ov", io.out_valid, 0);
    check("abort_clear", cs_clear, 1);
    check("abort_done", done, 1);
    adv();
    sample();
    check("abort_idle", busy, 0);
    adv();
    check("abort_acc", nacc, 11);
    check("abort_res", nres, 2);
  endtask

  task automatic reset_mid();
    int guard;
    start_frame();
    guard = 0;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    while (nacc < 12 && guard < 200) begin
      guard++;
      io.in_data = 8'($urandom);
      sample();
      adv();
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    sample();
    check("rst_pre_ov", io.out_valid, 1);
    adv();
    reset = 1'b1;
    start = 1'b1;
    io.in_valid = 1'b1;
    sample();
    adv();
    sample();
    check("rst_ready", io.in_ready, 0);
    check("rst_shift", cs_shift, 0);
    check("rst_clear", cs_clear, 0);
    check("rst_y", io.y, 0);
    check("rst_ov", io.out_valid, 0);
    check("rst_last", io.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    adv();
    reset = 1'b0;
    start = 1'b0;
    sample();
    check("rst_nostart", busy, 0);
    check("rst_noready", io.in_ready, 0);
    adv();
    io.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    hold = 1'b0;
    hold_y = '0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    frame_begin();
    repeat (3) begin
      sample();
      adv();
    end
    sample();
    check("init_ready", io.in_ready, 0);
    check("init_ov", io.out_valid, 0);
    check("init_y", io.y, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_clear", cs_clear, 0);
    adv();
    reset = 1'b0;
    run_frame(100, 100, 1, 1'b0);
    run_frame(100, 100, 2, 1'b0);
    run_frame(100, 100, 0, 1'b1);
    abort_frame();
    run_frame(100, 100, 0, 1'b0);
    reset_mid();
    for (int k = 0; k < 4; k++) run_frame(50, 60, 0, 1'b0);
    run_frame(80, 30, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
